// File: rtl/dds_decim_fifo.sv
// ---------------------------------------------------------------------------
// dds_decim_fifo
//
// Consumes the DDS sine generator's unsigned samples (qualified by its
// data-change strobe). Every D accepted samples are summed into one value
// (integrate-and-dump decimation). These sums are queued in a 16-deep
// first-word-fall-through FIFO. The FIFO has a valid/ready interface toward
// the polyphase filter chain.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous, active-low reset
//   enable      block enable; low clears the integrator and relatches D
//   dec_factor  decimation factor D (0 behaves as 1)
//   din         unsigned input sample
//   din_change  sample-valid strobe from the DDS
//   m_data      decimated sum at the FIFO head (0 while empty)
//   m_valid     FIFO non-empty
//   m_ready     downstream accepts m_data
//   fill        FIFO occupancy, 0..16
//   overflow    sticky: a dump was dropped because the FIFO was full
//   clr_ovf     synchronous clear of overflow
// ---------------------------------------------------------------------------
module dds_decim_fifo #(
  parameter int DATA_W = 8,
  parameter int DEC_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [DEC_W-1:0]        dec_factor,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_change,
  output logic [DATA_W+DEC_W-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_W:0]         fill,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int SUM_W = DATA_W + DEC_W;
  localparam int DEPTH = 1 << ADDR_W;

  // Integrator state
  logic [SUM_W-1:0]  acc;
  logic [DEC_W-1:0]  cnt;
  logic [DEC_W-1:0]  dec_q;

  // FIFO state
  logic [SUM_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic [DEC_W-1:0]  dec_eff;
  logic              accept;
  logic              dump;
  logic [SUM_W-1:0]  sum;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;

  // A requested factor of 0 is treated as 1.
  assign dec_eff = (dec_factor == '0) ? DEC_W'(1) : dec_factor;

  assign accept = enable && din_change;
  assign dump   = accept && (cnt == dec_q - DEC_W'(1));
  assign sum    = acc + SUM_W'(din);

  // Full and empty come from the occupancy count. When the FIFO is full,
  // the write and read pointers are equal, the same as when it is empty.
  assign full  = (fill == (ADDR_W+1)'(DEPTH));
  assign empty = (fill == '0);

  // A pop at full frees a slot in the same cycle, so a simultaneous dump
  // is still stored.
  assign pop  = !empty && m_ready;
  assign push = dump && (!full || pop);
  assign drop = dump && full && !pop;

  assign m_valid = !empty;
  assign m_data  = empty ? '0 : mem[rd_ptr];

  // Integrator. The factor is relatched only at block boundaries, so a
  // change to dec_factor mid-block applies to the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      dec_q <= DEC_W'(1);
    end else if (!enable) begin
      acc   <= '0;
      cnt   <= '0;
      dec_q <= dec_eff;
    end else if (accept) begin
      if (dump) begin
        acc   <= '0;
        cnt   <= '0;
        dec_q <= dec_eff;
      end else begin
        acc <= sum;
        cnt <= cnt + DEC_W'(1);
      end
    end
  end

  // FIFO storage. This is not reset, because m_data is masked while the
  // FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sum;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + (ADDR_W+1)'(1);
        2'b01:   fill <= fill - (ADDR_W+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Sticky overflow. If a drop and a clear happen in the same cycle, the
  // drop wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_decim_fifo.sv
// ---------------------------------------------------------------------------
// tb_dds_decim_fifo
//
// Self-checking bench for dds_decim_fifo. A behavioural model tracks the
// current block (running sum, sample count, factor) and holds the FIFO as a
// queue of integers. Each cycle the DUT's handshake outputs are compared
// against that model. Directed scenarios also check the popped values
// against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dds_decim_fifo;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  dec_factor;
  logic [7:0]  din;
  logic        din_change;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  fill;
  logic        overflow;
  logic        clr_ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  int blk_sum;
  int blk_n;
  int blk_d;
  bit ovf;

  // Values actually popped from the DUT, in order
  int dut_out[$];

  dds_decim_fifo #(.DATA_W(8), .DEC_W(4), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .dec_factor (dec_factor),
    .din        (din),
    .din_change (din_change),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fill       (fill),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Counts one comparison and reports it if the values differ
  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clears the model to its post-reset state
  task automatic modelReset();
    q.delete();
    blk_sum = 0;
    blk_n   = 0;
    blk_d   = 1;
    ovf     = 0;
  endtask

  // Compares every DUT output with the model
  task automatic checkModel();
    checkOutput("m_valid", int'(m_valid), (q.size() != 0) ? 1 : 0);
    checkOutput("fill", int'(fill), q.size());
    checkOutput("overflow", int'(overflow), int'(ovf));
    if (q.size() != 0) checkOutput("m_data", int'(m_data), q[0]);
  endtask

  // Drives one cycle of inputs, steps the model across the edge, then checks
  task automatic applyStimulus(input bit en, input int dec, input int d,
                               input bit chg, input bit rdy, input bit clr);
    bit pop_now;
    bit dumped;
    int dump_val;
    enable     = en;
    dec_factor = 4'(dec);
    din        = 8'(d);
    din_change = chg;
    m_ready    = rdy;
    clr_ovf    = clr;
    if (m_valid && m_ready) dut_out.push_back(int'(m_data));
    pop_now  = (q.size() != 0) && rdy;
    dumped   = 0;
    dump_val = 0;
    if (!en) begin
      blk_sum = 0;
      blk_n   = 0;
      blk_d   = (dec == 0) ? 1 : dec;
    end else if (chg) begin
      blk_sum += d;
      blk_n++;
      if (blk_n == blk_d) begin
        dumped   = 1;
        dump_val = blk_sum;
        blk_sum  = 0;
        blk_n    = 0;
        blk_d    = (dec == 0) ? 1 : dec;
      end
    end
    @(posedge clk);
    #1;
    if (pop_now) void'(q.pop_front());
    if (clr) ovf = 0;
    if (dumped) begin
      if (q.size() < 16) q.push_back(dump_val);
      else ovf = 1;
    end
    checkModel();
  endtask

  task automatic idle(input int n, input int dec);
    for (int i = 0; i < n; i++) applyStimulus(1, dec, 0, 0, 1, 0);
  endtask

  initial begin
    int bias;
    rst_n      = 1'b0;
    enable     = 1'b0;
    dec_factor = '0;
    din        = '0;
    din_change = 1'b0;
    m_ready    = 1'b0;
    clr_ovf    = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", int'(m_valid), 0);
    checkOutput("reset_fill", int'(fill), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_m_data", int'(m_data), 0);
    rst_n = 1'b1;

    // D=4: 10..80 gives sums 100 and 260
    applyStimulus(0, 4, 0, 0, 1, 0);
    dut_out.delete();
    for (int i = 1; i <= 8; i++) applyStimulus(1, 4, 10 * i, 1, 1, 0);
    idle(3, 4);
    checkOutput("d4_count", dut_out.size(), 2);
    if (dut_out.size() == 2) begin
      checkOutput("d4_sum0", dut_out[0], 100);
      checkOutput("d4_sum1", dut_out[1], 260);
    end
    checkOutput("d4_fill_zero", int'(fill), 0);

    // D=1: strobe every third cycle with 0xFF
    applyStimulus(0, 1, 0, 0, 1, 0);
    dut_out.delete();
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 255, (i % 3) == 0, 1, 0);
    idle(2, 1);
    checkOutput("d1_count", dut_out.size(), 4);
    foreach (dut_out[i]) checkOutput("d1_value", dut_out[i], 255);

    // Overflow: 17 samples into a stalled FIFO, clear, drain 1..16
    dut_out.delete();
    for (int i = 1; i <= 17; i++) applyStimulus(1, 1, i, 1, 0, 0);
    checkOutput("ovf_fill", int'(fill), 16);
    checkOutput("ovf_set", int'(overflow), 1);
    applyStimulus(1, 1, 0, 0, 0, 1);
    checkOutput("ovf_clear", int'(overflow), 0);
    idle(18, 1);
    checkOutput("ovf_drain_count", dut_out.size(), 16);
    foreach (dut_out[i]) checkOutput("ovf_drain_order", dut_out[i], i + 1);

    // Full with a simultaneous pop: push accepted, no overflow
    dut_out.delete();
    for (int i = 1; i <= 16; i++) applyStimulus(1, 1, i, 1, 0, 0);
    applyStimulus(1, 1, 17, 1, 1, 0);
    checkOutput("fullpop_fill", int'(fill), 16);
    checkOutput("fullpop_ovf", int'(overflow), 0);
    idle(18, 1);
    checkOutput("fullpop_count", dut_out.size(), 17);
    foreach (dut_out[i]) checkOutput("fullpop_order", dut_out[i], i + 1);

    // Factor change mid-block: D=3 block finishes, then D=2, then 0 -> 1
    applyStimulus(0, 3, 0, 0, 1, 0);
    dut_out.delete();
    applyStimulus(1, 3, 1, 1, 1, 0);
    applyStimulus(1, 2, 2, 1, 1, 0);
    applyStimulus(1, 2, 3, 1, 1, 0);
    applyStimulus(1, 2, 4, 1, 1, 0);
    applyStimulus(1, 0, 5, 1, 1, 0);
    applyStimulus(1, 0, 7, 1, 1, 0);
    applyStimulus(1, 0, 8, 1, 1, 0);
    idle(2, 0);
    checkOutput("dchg_count", dut_out.size(), 4);
    if (dut_out.size() == 4) begin
      checkOutput("dchg_d3", dut_out[0], 6);
      checkOutput("dchg_d2", dut_out[1], 9);
      checkOutput("dchg_d0a", dut_out[2], 7);
      checkOutput("dchg_d0b", dut_out[3], 8);
    end

    // Enable low discards the partial sum
    applyStimulus(0, 4, 0, 0, 1, 0);
    dut_out.delete();
    applyStimulus(1, 4, 9, 1, 1, 0);
    applyStimulus(1, 4, 9, 1, 1, 0);
    applyStimulus(0, 4, 9, 1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 4, 5, 1, 1, 0);
    idle(2, 4);
    checkOutput("en_count", dut_out.size(), 1);
    if (dut_out.size() == 1) checkOutput("en_sum", dut_out[0], 20);

    // Asynchronous reset mid-block with three entries queued
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(1, 1, 40 + i, 1, 0, 0);
    applyStimulus(0, 2, 0, 0, 0, 0);
    applyStimulus(1, 2, 50, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_m_valid", int'(m_valid), 0);
    checkOutput("arst_fill", int'(fill), 0);
    checkOutput("arst_overflow", int'(overflow), 0);
    checkOutput("arst_m_data", int'(m_data), 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 2, 0, 0, 1, 0);
    dut_out.delete();
    applyStimulus(1, 2, 30, 1, 1, 0);
    applyStimulus(1, 2, 31, 1, 1, 0);
    idle(2, 2);
    checkOutput("arst_fresh_count", dut_out.size(), 1);
    if (dut_out.size() == 1) checkOutput("arst_fresh_sum", dut_out[0], 61);

    // Randomized traffic with varying backpressure
    bias = 2;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 150) == 0) bias = $urandom_range(0, 4);
      applyStimulus($urandom_range(0, 15) != 0,
                    $urandom_range(0, 15),
                    $urandom_range(0, 255),
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) < bias,
                    $urandom_range(0, 31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
